sdram_bist: RTL and testbench
=============================

# sdram_bist

Self-test traffic generator that drives the request side of `sdram_controller3` in place of a host. It sweeps a write pass over an address range with an address-derived pattern, then a read-back pass, comparing every word. It stops on the first mismatch or controller timeout and reports status. It brings hardware-level SDRAM checkout on the board to the same coverage as the simulation sweep.

## Interface
Parameters:
- `ADDR_WIDTH`, 24: width of controller word address.
- `DATA_WIDTH`, 32: width of controller data words.
- `ADDR_MAX`, 1<<20: number of words tested; addresses `0 .. ADDR_MAX-1`.
- `PATTERN_XOR`, 32'h0000_0000: XOR mask; expected data for address `a` is `zero-extend(a) ^ PATTERN_XOR`.
- `TIMEOUT`, 1023: maximum cycles to wait for a controller completion strobe.

Ports:
- `CLOCK_50`, in, 1: the single clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin a test; sampled only in IDLE, DONE or FAIL.
- `address`, out, ADDR_WIDTH: request address to controller.
- `req_write`, out, 1: one-cycle write request pulse.
- `req_read`, out, 1: one-cycle read request pulse.
- `data_out`, out, DATA_WIDTH: write data to controller `data_in`.
- `data_in`, in, DATA_WIDTH: read data from controller `data_out`.
- `write_complete`, in, 1: controller write-done strobe.
- `data_valid`, in, 1: controller read-data-valid strobe.
- `busy`, out, 1: test in progress.
- `done`, out, 1: last test passed all addresses.
- `fail`, out, 1: last test stopped on error.
- `timeout`, out, 1: the failure was a timeout, not a mismatch.
- `fail_addr`, out, ADDR_WIDTH: address of the failing access.
- `fail_data`, out, DATA_WIDTH: data read at the failure; 0 on timeout.

## Operation
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE, FAIL.
- Reset values:
  - State IDLE; address counter 0.
  - All outputs 0, including `address`, `data_out`, `fail_addr` and `fail_data`.
- IDLE/DONE/FAIL with `start`=1:
  - Clear `done`, `fail`, `timeout`, `fail_addr`, `fail_data`; counter := 0.
  - Set `busy`; go to WR_REQ.
- WR_REQ:
  - Drive `address`=counter and `data_out`=pattern(counter).
  - Assert `req_write` for exactly this cycle; go to WR_WAIT.
- WR_WAIT waits for a rising edge of `write_complete` (current 1, registered previous 0).
  - If counter = ADDR_MAX-1: counter := 0, go to RD_REQ.
  - Else: counter += 1, go to WR_REQ.
- RD_REQ: drive `address`=counter, assert `req_read` for one cycle, go to RD_WAIT.
- RD_WAIT: on rising edge of `data_valid`, capture `data_in` into a register and go to CHECK.
- CHECK:
  - Captured ≠ pattern(counter): `fail_addr`:=counter, `fail_data`:=captured, go to FAIL.
  - Else, last address: go to DONE.
  - Else: counter += 1, go to RD_REQ.
- Timeout: a wait counter is cleared on entry to WR_WAIT/RD_WAIT and increments each cycle.
  - If it reaches TIMEOUT before the strobe edge: `fail_addr`:=counter, `fail_data`:=0, `timeout`:=1, go to FAIL.
  - If the strobe edge and TIMEOUT coincide, the strobe wins.
- DONE: `done`=1, `busy`=0. FAIL: `fail`=1, `busy`=0. Both hold until `start` or `rst`.
- `start` while `busy` is ignored.
- `rst` mid-test aborts immediately to the reset state; no further request pulses are issued.
- `address` and `data_out` hold their values from the REQ cycle through the corresponding WAIT state.
- Pattern arithmetic: `address` is zero-extended or truncated to DATA_WIDTH, then XORed with PATTERN_XOR.
- Counter is ADDR_WIDTH bits; ADDR_MAX ≤ 2^ADDR_WIDTH.

## Timing
- `start` to first `req_write`: 1 cycle; `req_write` high in the cycle after `start` is sampled.
- Write step: WR_WAIT entry → strobe edge seen → next `req_write` on the following cycle. Minimum 2 cycles per word plus controller latency.
- Read step: strobe edge → CHECK (1 cycle) → next `req_read` on the following cycle.
- Strobe edges are detected registered, so a strobe held high for many cycles counts once. A strobe already high on WAIT entry is not an edge.
- `done`/`fail` assert the cycle after the final CHECK or the timeout cycle.

## Test plan
- **Pass, small range.** ADDR_MAX=16, PATTERN_XOR=0, controller plus `sdr` model.
  - Expect 16 `req_write` pulses, then 16 `req_read` pulses with addresses 0..15.
  - Expect `done`=1, `fail`=0, `busy`=0.
- **Data mismatch.** Behavioural responder corrupts the read at address 5 (returns 0xDEAD).
  - Expect `fail`=1, `timeout`=0, `fail_addr`=5, `fail_data`=0xDEAD.
  - Expect no `req_read` after address 5.
- **Write timeout.** Responder never asserts `write_complete` for address 3; TIMEOUT=20.
  - Expect `fail`=1, `timeout`=1, `fail_addr`=3, `fail_data`=0, 20 cycles after the WR_WAIT entry.
- **Long strobe.** Responder holds `data_valid` high 5 cycles per read.
  - Expect each read counted once and the test to pass.
  - Expect `req_read` count = ADDR_MAX.
- **Reset mid-test.** Assert `rst` during the read pass at address 7.
  - Expect all outputs 0 the next cycle and no request pulses afterwards.
  - Then `start` runs a full pass to `done`=1.
- **Restart and XOR.** PATTERN_XOR=0xA5A5A5A5.
  - Expect write data at address 1 to be 0xA5A5A5A4.
  - After `done`, a second `start` clears `done` within 1 cycle and repeats the sweep.

Source files
------------

// File: rtl/sdram_bist_if.sv
// Request-side bus between the BIST engine and sdram_controller3.
// The master drives requests and the slave returns completion strobes.
interface sdram_bist_if #(
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  req_write;
    logic                  req_read;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_complete;
    logic                  data_valid;

    modport master (
        output address, req_write, req_read, data_out,
        input  data_in, write_complete, data_valid
    );

    modport slave (
        input  address, req_write, req_read, data_out,
        output data_in, write_complete, data_valid
    );
endinterface

// File: rtl/sdram_bist.sv
// Self-test traffic generator for the sdram_controller3 request port: writes an
// address-derived pattern over a range, reads it back and reports the first error.
module sdram_bist #(
    parameter int unsigned           ADDR_WIDTH  = 24,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_MAX    = 1 << 20,
    parameter logic [DATA_WIDTH-1:0] PATTERN_XOR = '0,
    parameter int unsigned           TIMEOUT     = 1023
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic                  start,
    sdram_bist_if.master          bus,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic                  timeout,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    localparam int unsigned           WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_MAX - 1);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK, DONE, FAIL
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] counter;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wc_prev;
    logic                  dv_prev;

    logic                  wr_edge;
    logic                  rd_edge;
    logic                  wait_expired;
    logic                  is_last;
    logic                  mismatch;
    logic [DATA_WIDTH-1:0] pattern;

    // The wait expires on the TIMEOUT-th WAIT cycle without a strobe edge.
    always_comb begin
        pattern      = DATA_WIDTH'(counter) ^ PATTERN_XOR;
        wr_edge      = bus.write_complete & ~wc_prev;
        rd_edge      = bus.data_valid & ~dv_prev;
        wait_expired = (wait_cnt == WAIT_LAST);
        is_last      = (counter == LAST_ADDR);
        mismatch     = (rd_data != pattern);
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) next_state = WR_REQ;
            end
            WR_REQ:  next_state = WR_WAIT;
            WR_WAIT: begin
                if (wr_edge)           next_state = is_last ? RD_REQ : WR_REQ;
                else if (wait_expired) next_state = FAIL;
            end
            RD_REQ:  next_state = RD_WAIT;
            RD_WAIT: begin
                if (rd_edge)           next_state = CHECK;
                else if (wait_expired) next_state = FAIL;
            end
            CHECK: begin
                if (mismatch)     next_state = FAIL;
                else if (is_last) next_state = DONE;
                else              next_state = RD_REQ;
            end
            default: next_state = IDLE;
        endcase
    end

    // Strobe history is tracked every cycle so a strobe already high on WAIT entry is not an edge.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            counter   <= '0;
            wait_cnt  <= '0;
            rd_data   <= '0;
            wc_prev   <= 1'b0;
            dv_prev   <= 1'b0;
            timeout   <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            wc_prev <= bus.write_complete;
            dv_prev <= bus.data_valid;
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        counter   <= '0;
                        timeout   <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
                    end
                end
                WR_REQ, RD_REQ: begin
                    wait_cnt <= '0;
                end
                WR_WAIT: begin
                    if (wr_edge) begin
                        counter <= is_last ? '0 : counter + 1'b1;
                    end else if (wait_expired) begin
                        timeout   <= 1'b1;
                        fail_addr <= counter;
                        fail_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (rd_edge) begin
                        rd_data <= bus.data_in;
                    end else if (wait_expired) begin
                        timeout   <= 1'b1;
                        fail_addr <= counter;
                        fail_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_addr <= counter;
                        fail_data <= rd_data;
                    end else if (!is_last) begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    counter <= '0;
                end
            endcase
        end
    end

    // The counter only moves on leaving a WAIT or CHECK, so address holds through each access.
    always_comb begin
        bus.address   = counter;
        bus.req_write = (state == WR_REQ);
        bus.req_read  = (state == RD_REQ);
        bus.data_out  = '0;
        if (state == WR_REQ || state == WR_WAIT) bus.data_out = pattern;
        busy = (state inside {WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, CHECK});
        done = (state == DONE);
        fail = (state == FAIL);
    end

endmodule

// File: tb/tb_sdram_bist.sv
// Bench for sdram_bist: a behavioural controller responder with knobs for corrupted
// reads, dropped writes and long strobes, plus a request-sequence scoreboard.
module tb_sdram_bist;

    localparam int          AW       = 24;
    localparam int          DW       = 32;
    localparam int          N        = 16;
    localparam int          TMO      = 20;
    localparam logic [31:0] XOR_MASK = 32'hA5A5A5A5;

    logic          clk_50 = 1'b0;
    logic          rst    = 1'b1;
    logic          start  = 1'b0;
    logic          busy;
    logic          done;
    logic          fail;
    logic          timeout;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    sdram_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    sdram_bist #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_MAX(N),
        .PATTERN_XOR(XOR_MASK), .TIMEOUT(TMO)
    ) dut (
        .CLOCK_50(clk_50), .rst(rst), .start(start), .bus(bus),
        .busy(busy), .done(done), .fail(fail), .timeout(timeout),
        .fail_addr(fail_addr), .fail_data(fail_data)
    );

    always #5 clk_50 = ~clk_50;

    int drop_addr    = -1;
    int corrupt_addr = -1;
    int hold_len     = 1;
    int lat          = 2;

    logic [DW-1:0] mem [0:N-1];

    // Responder: each strobe rises lat cycles after its request and stays high hold_len cycles.
    initial begin : responder
        int w_dly, w_hold, r_dly, r_hold, w_addr, r_addr;
        logic [DW-1:0] w_data;
        w_dly = 0; w_hold = 0; r_dly = 0; r_hold = 0; w_addr = 0; r_addr = 0; w_data = '0;
        bus.data_in = '0; bus.write_complete = 1'b0; bus.data_valid = 1'b0;
        forever begin
            @(negedge clk_50);
            if (w_hold > 0) w_hold--;
            if (r_hold > 0) r_hold--;
            if (w_dly > 0) begin
                w_dly--;
                if (w_dly == 0 && w_addr != drop_addr) begin
                    if (w_addr < N) mem[w_addr] = w_data;
                    w_hold = hold_len;
                end
            end
            if (r_dly > 0) begin
                r_dly--;
                if (r_dly == 0) begin
                    if (r_addr == corrupt_addr) bus.data_in = 32'hDEAD;
                    else if (r_addr < N)        bus.data_in = mem[r_addr];
                    else                        bus.data_in = '0;
                    r_hold = hold_len;
                end
            end
            if (bus.req_write) begin
                w_addr = int'(bus.address); w_data = bus.data_out; w_dly = lat;
            end
            if (bus.req_read) begin
                r_addr = int'(bus.address); r_dly = lat;
            end
            bus.write_complete = (w_hold > 0);
            bus.data_valid     = (r_hold > 0);
        end
    end

    int            nvec = 0;
    int            nerr = 0;
    int            wr_seen = 0;
    int            rd_seen = 0;
    int            cycle = 0;
    int            last_wr_cycle = 0;
    int            end_cycle = 0;
    bit            end_seen = 1'b0;
    logic [AW-1:0] last_req_addr = '0;
    logic [DW-1:0] wdata_at1 = '0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nvec++;
        if (actual !== expected) begin
            nerr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic start_test();
        wr_seen = 0;
        rd_seen = 0;
        @(negedge clk_50);
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        check_output("start_req_write", bus.req_write, 1);
        check_output("start_flags", {busy, done, fail, timeout}, 4'b1000);
        end_seen = 1'b0;
    endtask

    // Outcome is predicted from the fault knobs alone: first fault address decides everything.
    task automatic apply_stimulus(input string name, input int drop, input int corrupt,
                                  input int hold, input int latency);
        bit exp_done, exp_fail, exp_to;
        int exp_fa, exp_w, exp_r, budget;
        logic [DW-1:0] exp_fd;
        drop_addr = drop; corrupt_addr = corrupt; hold_len = hold; lat = latency;
        start_test();
        budget = 0;
        while (!(done || fail) && budget < 3000) begin
            @(negedge clk_50);
            budget++;
        end
        check_output({name, "_finished"}, done | fail, 1);
        repeat (12) @(negedge clk_50);
        if (drop >= 0) begin
            exp_done = 0; exp_fail = 1; exp_to = 1; exp_fa = drop; exp_fd = '0;
            exp_w = drop + 1; exp_r = 0;
        end else if (corrupt >= 0) begin
            exp_done = 0; exp_fail = 1; exp_to = 0; exp_fa = corrupt; exp_fd = 32'hDEAD;
            exp_w = N; exp_r = corrupt + 1;
        end else begin
            exp_done = 1; exp_fail = 0; exp_to = 0; exp_fa = 0; exp_fd = '0;
            exp_w = N; exp_r = N;
        end
        check_output({name, "_done"}, done, exp_done);
        check_output({name, "_fail"}, fail, exp_fail);
        check_output({name, "_timeout"}, timeout, exp_to);
        check_output({name, "_busy"}, busy, 0);
        check_output({name, "_fail_addr"}, fail_addr, exp_fa);
        check_output({name, "_fail_data"}, fail_data, exp_fd);
        check_output({name, "_writes"}, wr_seen, exp_w);
        check_output({name, "_reads"}, rd_seen, exp_r);
    endtask

    initial begin : driver
        int budget;
        fork
            forever begin
                @(negedge clk_50);
                cycle++;
                if (bus.req_write) begin
                    check_output("wr_addr", bus.address, wr_seen);
                    check_output("wr_data", bus.data_out, 32'(wr_seen) ^ XOR_MASK);
                    if (wr_seen == 1) wdata_at1 = bus.data_out;
                    last_wr_cycle = cycle;
                    wr_seen++;
                end
                if (bus.req_read) begin
                    check_output("rd_addr", bus.address, rd_seen);
                    check_output("rd_after_writes", wr_seen, N);
                    rd_seen++;
                end
                if (bus.req_write || bus.req_read) last_req_addr = bus.address;
                else if (busy) check_output("addr_hold", bus.address, last_req_addr);
                if ((done || fail) && !end_seen) begin
                    end_seen  = 1'b1;
                    end_cycle = cycle;
                end
            end
        join_none

        repeat (3) @(negedge clk_50);
        check_output("reset_flags", {busy, done, fail, timeout, bus.req_write, bus.req_read}, 0);
        check_output("reset_address", bus.address, 0);
        check_output("reset_data_out", bus.data_out, 0);
        check_output("reset_fail_info", {fail_addr, fail_data}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk_50);

        $display("[TB] pass sweep");
        apply_stimulus("pass", -1, -1, 1, 2);
        check_output("xor_data_addr1", wdata_at1, 32'hA5A5A5A4);

        $display("[TB] restart from done");
        apply_stimulus("restart", -1, -1, 1, 2);

        $display("[TB] data mismatch at 5");
        apply_stimulus("mismatch", -1, 5, 1, 2);
        check_output("mismatch_literal", {fail_addr, fail_data}, {24'd5, 32'h0000DEAD});

        $display("[TB] write timeout at 3");
        apply_stimulus("wr_timeout", 3, -1, 1, 2);
        check_output("timeout_latency", end_cycle - last_wr_cycle - 1, TMO);

        $display("[TB] long strobes");
        apply_stimulus("long_strobe", -1, -1, 5, 5);

        $display("[TB] reset during read pass");
        drop_addr = -1; corrupt_addr = -1; hold_len = 1; lat = 2;
        start_test();
        budget = 0;
        while (!(bus.req_read && bus.address == 7) && budget < 2000) begin
            @(negedge clk_50);
            budget++;
        end
        check_output("reach_read7", bus.req_read && bus.address == 7, 1);
        rst = 1'b1;
        @(negedge clk_50);
        check_output("midrst_flags", {busy, done, fail, timeout, bus.req_write, bus.req_read}, 0);
        check_output("midrst_address", bus.address, 0);
        check_output("midrst_data_out", bus.data_out, 0);
        check_output("midrst_fail_info", {fail_addr, fail_data}, 0);
        repeat (3) @(negedge clk_50);
        rst = 1'b0;
        repeat (15) @(negedge clk_50);
        check_output("midrst_writes", wr_seen, N);
        check_output("midrst_reads", rd_seen, 8);
        apply_stimulus("after_reset", -1, -1, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
